// File: rtl/hazard_ctrl.sv
// Decode-stage issue control: register scoreboard, mul/div and CSR
// serialisation, and redirect-driven front-end flush sequencing.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-low reset
//   dec_*_i             instruction currently held in decode
//   wb_valid_i/wb_rd_i  writer retiring this cycle
//   md_done_i           mul/div completion pulse
//   redirect_i          execute-stage redirect pulse
//   issue_o             instruction leaves decode this cycle
//   stall_o / flush_o   decode stall and fetch/decode flush
//   md_busy_o           mul/div unit occupied
//   inflight_o          scoreboard entries set
//   err_o               sticky protocol error

module hazard_ctrl #(
  parameter int MAX_INFLIGHT = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_valid_i,
  input  logic [4:0] dec_rs1_i,
  input  logic [4:0] dec_rs2_i,
  input  logic       dec_rs1_used_i,
  input  logic       dec_rs2_used_i,
  input  logic [4:0] dec_rd_i,
  input  logic       dec_rd_wr_i,
  input  logic [1:0] dec_class_i,
  input  logic       wb_valid_i,
  input  logic [4:0] wb_rd_i,
  input  logic       md_done_i,
  input  logic       redirect_i,
  output logic       issue_o,
  output logic       stall_o,
  output logic       flush_o,
  output logic       md_busy_o,
  output logic [4:0] inflight_o,
  output logic       err_o
);

  localparam logic [1:0] C_MULDIV = 2'd2;
  localparam logic [1:0] C_SERIAL = 2'd3;
  localparam logic [4:0] MAX_N    = 5'(MAX_INFLIGHT);
  localparam logic [3:0] RELOAD   = 4'(FLUSH_CYCLES - 1);
  // With a single flush cycle the redirect cycle itself is enough,
  // so the FLUSH state is never entered.
  localparam bit HAS_FLUSH = (FLUSH_CYCLES > 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_FLUSH  = 2'd1,
    S_SERIAL = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nx;
  logic [31:0] r_sb;
  logic [31:0] w_sb_nx;
  logic [4:0]  r_inflight;
  logic [4:0]  w_inflight_nx;
  logic        r_md_busy;
  logic        w_md_busy_nx;
  logic        r_err;
  logic        w_err_nx;

  logic w_rd_nz;
  logic w_raw;
  logic w_waw;
  logic w_full;
  logic w_md_conf;
  logic w_ser_blk;
  logic w_in_flush;
  logic w_stall;
  logic w_flush;
  logic w_issue;
  logic w_set;
  logic w_wb_hit;
  logic w_is_md;
  logic w_is_ser;

  assign w_is_md  = (dec_class_i == C_MULDIV);
  assign w_is_ser = (dec_class_i == C_SERIAL);
  assign w_rd_nz  = dec_rd_wr_i & (dec_rd_i != 5'd0);

  // Hazards look only at registered scoreboard state: a same-cycle
  // writeback releases the stall one cycle later.
  assign w_raw =
      (dec_rs1_used_i & (dec_rs1_i != 5'd0) & r_sb[dec_rs1_i])
    | (dec_rs2_used_i & (dec_rs2_i != 5'd0) & r_sb[dec_rs2_i]);
  assign w_waw     = w_rd_nz & r_sb[dec_rd_i];
  assign w_full    = w_rd_nz & (r_inflight == MAX_N);
  assign w_md_conf = w_is_md & r_md_busy;
  assign w_ser_blk =
      (w_is_ser & ((r_inflight != 5'd0) | r_md_busy))
    | (r_state == S_SERIAL);
  assign w_in_flush = (r_state == S_FLUSH);

  always_comb begin
    w_stall = (dec_valid_i
      & (w_raw | w_waw | w_full | w_md_conf | w_ser_blk))
      | w_in_flush;
    w_flush = redirect_i | w_in_flush;
    if (!reset) begin
      w_stall = 1'b1;
      w_flush = 1'b1;
    end
  end

  assign w_issue  = dec_valid_i & ~w_stall & ~w_flush;
  assign w_set    = w_issue & w_rd_nz;
  assign w_wb_hit = wb_valid_i & (wb_rd_i != 5'd0) & r_sb[wb_rd_i];

  // Scoreboard, in-flight count, mul/div occupancy and error flag.
  always_comb begin
    w_sb_nx = r_sb;
    if (w_wb_hit) w_sb_nx[wb_rd_i] = 1'b0;
    if (w_set)    w_sb_nx[dec_rd_i] = 1'b1;

    w_inflight_nx = r_inflight;
    unique case ({w_set, w_wb_hit})
      2'b10:   w_inflight_nx = r_inflight + 5'd1;
      2'b01:   w_inflight_nx = r_inflight - 5'd1;
      default: w_inflight_nx = r_inflight;
    endcase

    w_md_busy_nx = r_md_busy;
    if (md_done_i)         w_md_busy_nx = 1'b0;
    if (w_issue & w_is_md) w_md_busy_nx = 1'b1;

    w_err_nx = r_err
      | (wb_valid_i & ~w_wb_hit)
      | (md_done_i & ~r_md_busy);
  end

  // Control FSM. The counter holds the FLUSH cycles still owed after
  // the redirect cycle, so flush_o spans FLUSH_CYCLES cycles in total.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_RUN: begin
        if (redirect_i) begin
          w_state_nx = HAS_FLUSH ? S_FLUSH : S_RUN;
          w_cnt_nx   = RELOAD;
        end else if (w_issue & w_is_ser) begin
          w_state_nx = S_SERIAL;
        end
      end
      S_FLUSH: begin
        if (redirect_i) begin
          w_cnt_nx = RELOAD;
        end else if (r_cnt <= 4'd1) begin
          w_state_nx = S_RUN;
          w_cnt_nx   = 4'd0;
        end else begin
          w_cnt_nx = r_cnt - 4'd1;
        end
      end
      S_SERIAL: begin
        if (redirect_i) begin
          w_state_nx = HAS_FLUSH ? S_FLUSH : S_RUN;
          w_cnt_nx   = RELOAD;
        end else if ((r_inflight == 5'd0) & ~w_issue) begin
          w_state_nx = S_RUN;
        end
      end
      default: begin
        w_state_nx = S_RUN;
        w_cnt_nx   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_RUN;
      r_cnt      <= 4'd0;
      r_sb       <= 32'd0;
      r_inflight <= 5'd0;
      r_md_busy  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_sb       <= w_sb_nx;
      r_inflight <= w_inflight_nx;
      r_md_busy  <= w_md_busy_nx;
      r_err      <= w_err_nx;
    end
  end

  assign issue_o    = w_issue;
  assign stall_o    = w_stall;
  assign flush_o    = w_flush;
  assign md_busy_o  = r_md_busy;
  assign inflight_o = r_inflight;
  assign err_o      = r_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expectations queued when stimulus
// is driven, popped and asserted at the following falling edge.

module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic       dec_valid_i;
  logic [4:0] dec_rs1_i;
  logic [4:0] dec_rs2_i;
  logic       dec_rs1_used_i;
  logic       dec_rs2_used_i;
  logic [4:0] dec_rd_i;
  logic       dec_rd_wr_i;
  logic [1:0] dec_class_i;
  logic       wb_valid_i;
  logic [4:0] wb_rd_i;
  logic       md_done_i;
  logic       redirect_i;
  logic       issue_o;
  logic       stall_o;
  logic       flush_o;
  logic       md_busy_o;
  logic [4:0] inflight_o;
  logic       err_o;

  hazard_ctrl #(.MAX_INFLIGHT(4), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .dec_valid_i(dec_valid_i),
    .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i),
    .dec_rs1_used_i(dec_rs1_used_i),
    .dec_rs2_used_i(dec_rs2_used_i),
    .dec_rd_i(dec_rd_i), .dec_rd_wr_i(dec_rd_wr_i),
    .dec_class_i(dec_class_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
    .md_done_i(md_done_i), .redirect_i(redirect_i),
    .issue_o(issue_o), .stall_o(stall_o), .flush_o(flush_o),
    .md_busy_o(md_busy_o), .inflight_o(inflight_o),
    .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int ISS = 0;
  localparam int STL = 1;
  localparam int FLS = 2;
  localparam int MDB = 3;
  localparam int INF = 4;
  localparam int ERR = 5;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic E(input string tag, input int sel, input int v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = 8'(v);
    q.push_back(e);
  endtask

  function automatic logic [7:0] obs(input int sel);
    case (sel)
      ISS:     return {7'd0, issue_o};
      STL:     return {7'd0, stall_o};
      FLS:     return {7'd0, flush_o};
      MDB:     return {7'd0, md_busy_o};
      INF:     return {3'd0, inflight_o};
      default: return {7'd0, err_o};
    endcase
  endfunction

  task automatic step();
    exp_t       e;
    logic [7:0] o;
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d",
               e.tag, o, e.exp);
      end
    end
    @(posedge clk);
    #1;
    wb_valid_i = 1'b0;
    md_done_i  = 1'b0;
    redirect_i = 1'b0;
  endtask

  task automatic ins(input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2,
                     input logic [4:0] rd, input logic wr,
                     input logic [1:0] cls);
    dec_valid_i    = 1'b1;
    dec_rs1_i      = rs1;
    dec_rs1_used_i = u1;
    dec_rs2_i      = rs2;
    dec_rs2_used_i = u2;
    dec_rd_i       = rd;
    dec_rd_wr_i    = wr;
    dec_class_i    = cls;
  endtask

  task automatic nop();
    dec_valid_i = 1'b0;
    dec_rd_wr_i = 1'b0;
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_valid_i = 1'b1;
    wb_rd_i    = rd;
  endtask

  initial begin
    reset      = 1'b0;
    wb_valid_i = 1'b0;
    wb_rd_i    = 5'd0;
    md_done_i  = 1'b0;
    redirect_i = 1'b0;
    ins(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'd0);

    for (int i = 0; i < 3; i++) begin
      E("rst_stall", STL, 1);
      E("rst_flush", FLS, 1);
      E("rst_issue", ISS, 0);
      E("rst_inflight", INF, 0);
      E("rst_mdbusy", MDB, 0);
      E("rst_err", ERR, 0);
      step();
    end
    reset = 1'b1;

    E("first_issue", ISS, 1);
    E("first_stall", STL, 0);
    E("first_inflight", INF, 0);
    step();

    ins(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 2'd0);
    E("raw_inflight", INF, 1);
    E("raw_stall", STL, 1);
    E("raw_issue", ISS, 0);
    step();
    wb(5'd5);
    E("raw_wb_stall", STL, 1);
    E("raw_wb_issue", ISS, 0);
    step();
    E("raw_release", ISS, 1);
    E("raw_inflight0", INF, 0);
    step();

    ins(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 2'd0);
    E("x0_issue", ISS, 1);
    E("x0_inflight", INF, 1);
    step();
    nop();
    wb(5'd6);
    E("idle_stall", STL, 0);
    E("idle_issue", ISS, 0);
    step();

    for (int r = 1; r <= 4; r++) begin
      ins(5'd0, 1'b0, 5'd0, 1'b0, 5'(r), 1'b1, 2'd0);
      E("full_fill", ISS, 1);
      step();
    end
    ins(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'd0);
    E("full_inflight", INF, 4);
    E("full_stall", STL, 1);
    E("full_issue", ISS, 0);
    step();
    ins(5'd10, 1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 2'd1);
    E("full_store", ISS, 1);
    step();
    ins(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'd0);
    wb(5'd1);
    E("full_wb_stall", STL, 1);
    E("full_wb_inflight", INF, 4);
    step();
    E("full_release", ISS, 1);
    E("full_rel_inflight", INF, 3);
    step();
    nop();
    wb(5'd2);
    E("full_inflight4", INF, 4);
    step();
    wb(5'd3);
    step();
    wb(5'd4);
    step();
    wb(5'd7);
    step();
    E("drain_inflight", INF, 0);
    E("drain_err", ERR, 0);
    step();

    ins(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 2'd2);
    E("mul_issue", ISS, 1);
    E("mul_idle", MDB, 0);
    step();
    ins(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'd2);
    E("mul_busy", MDB, 1);
    E("mul2_stall", STL, 1);
    step();
    md_done_i = 1'b1;
    E("mul2_done_stall", STL, 1);
    E("mul2_done_issue", ISS, 0);
    step();
    E("mul2_issue", ISS, 1);
    E("mul2_mdbusy", MDB, 0);
    step();
    nop();
    md_done_i = 1'b1;
    E("mul2_busy", MDB, 1);
    E("mul_err0", ERR, 0);
    step();
    wb(5'd8);
    E("mul_free", MDB, 0);
    step();
    wb(5'd9);
    step();
    md_done_i = 1'b1;
    E("stray_pre_err", ERR, 0);
    step();
    E("stray_err", ERR, 1);
    E("stray_inflight", INF, 0);
    step();

    ins(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 2'd0);
    E("ser_w1", ISS, 1);
    step();
    ins(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 2'd0);
    E("ser_w2", ISS, 1);
    step();
    ins(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 2'd3);
    E("csr_stall", STL, 1);
    E("csr_inflight", INF, 2);
    step();
    wb(5'd10);
    E("csr_stall_wb1", STL, 1);
    step();
    wb(5'd11);
    E("csr_stall_wb2", STL, 1);
    E("csr_inflight1", INF, 1);
    step();
    E("csr_issue", ISS, 1);
    E("csr_inflight0", INF, 0);
    step();
    ins(5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 2'd0);
    E("ser_stall", STL, 1);
    E("ser_inflight", INF, 1);
    step();
    wb(5'd12);
    E("ser_wb_stall", STL, 1);
    step();
    E("ser_exit_stall", STL, 1);
    E("ser_exit_inflight", INF, 0);
    step();
    E("ser_after_issue", ISS, 1);
    step();
    nop();
    wb(5'd13);
    E("ser_after_inflight", INF, 1);
    step();

    ins(5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 2'd0);
    E("redir_setup", ISS, 1);
    step();
    ins(5'd14, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
    redirect_i = 1'b1;
    E("redir_flush", FLS, 1);
    E("redir_issue", ISS, 0);
    E("redir_inflight", INF, 1);
    step();
    E("flush2", FLS, 1);
    E("flush2_issue", ISS, 0);
    step();
    E("flush_end", FLS, 0);
    E("sb_kept", STL, 1);
    E("sb_inflight", INF, 1);
    step();
    redirect_i = 1'b1;
    E("redir2_flush", FLS, 1);
    step();
    redirect_i = 1'b1;
    E("re_redir_flush", FLS, 1);
    step();
    E("ext_flush", FLS, 1);
    E("ext_issue", ISS, 0);
    step();
    wb(5'd14);
    E("ext_end", FLS, 0);
    E("ext_sb_kept", STL, 1);
    step();
    E("post_wb_issue", ISS, 1);
    E("post_wb_inflight", INF, 0);
    E("err_sticky", ERR, 1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
